// File: rtl/fb_pkg.sv
// fb_pkg: shared types, sizes and pixel-merge helper for the frame-buffer arbiter.
// The CLEAR state exists only when FB_CLEAR_EN is defined.
package fb_pkg;
  localparam int PIX_W = 2;
  localparam int WORD_W = 16;
  localparam int NUM_WORDS = 512;
`ifdef FB_CLEAR_EN
  typedef enum logic [1:0] {IDLE, RD_WAIT, RMW_WR, CLEAR} fb_state_t;
`else
  typedef enum logic [1:0] {IDLE, RD_WAIT, RMW_WR} fb_state_t;
`endif
  typedef logic [11:0] fb_pix_addr_t;
  typedef logic [8:0] fb_word_addr_t;
  function automatic logic [WORD_W-1:0] merge_pix(input logic [WORD_W-1:0] w, input logic [2:0] s, input logic [PIX_W-1:0] d);
    logic [WORD_W-1:0] m;
    m = w;
    m[s*PIX_W +: PIX_W] = d;
    return m;
  endfunction
endpackage

// File: rtl/fb_wr_fifo.sv
// fb_wr_fifo: synchronous write-request FIFO with full/empty flags; DEPTH must be a power of two.
module fb_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign full = r_cnt == (AW+1)'(DEPTH);
  assign empty = r_cnt == '0;
  assign w_push = push && !full;
  assign w_pop = pop && !empty;
  assign dout = r_mem[r_rp];
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= r_wp + AW'(w_push);
      r_rp <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter: single-port SPRAM owner; VGA reads always win, SPI pixel writes retire as RMW.
// Define FB_CLEAR_EN to add the clearReq/clearBusy full-frame zeroing sweep.
module framebuffer_arbiter
  import fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        mainClk,
  input  logic        reset,
  input  logic        wrValid,
  input  logic [11:0] wrAddr,
  input  logic [1:0]  wrData,
  output logic        wrReady,
  input  logic        rdReq,
  input  logic [8:0]  rdAddr,
  output logic        rdValid,
  output logic [15:0] rdData,
  output logic        rdOverflow,
  output logic [13:0] ramAddr,
  output logic [15:0] ramDataIn,
  output logic [3:0]  ramMaskWren,
  output logic        ramWren,
`ifdef FB_CLEAR_EN
  input  logic        clearReq,
  output logic        clearBusy,
`endif
  input  logic [15:0] ramDataOut
);
  fb_state_t r_state, w_next;
  logic r_pend, r_ovf, r_rd_valid;
  fb_word_addr_t r_pend_addr;
  fb_pix_addr_t r_hold_addr;
  logic [PIX_W-1:0] r_hold_data;
  logic [WORD_W-1:0] r_rd_data;
  logic [13:0] w_head;
  logic w_full, w_empty, w_cand, w_issue, w_pop, w_clr_busy;
  fb_word_addr_t w_rd_addr;
  assign wrReady = !w_full && !reset;
  assign rdValid = r_rd_valid;
  assign rdData = r_rd_data;
  assign rdOverflow = r_ovf;
  assign ramMaskWren = 4'b1111;
  assign w_cand = rdReq || r_pend;
  assign w_rd_addr = r_pend ? r_pend_addr : rdAddr;
`ifdef FB_CLEAR_EN
  logic r_clr_busy;
  fb_word_addr_t r_clr_cnt;
  assign w_clr_busy = r_clr_busy;
  assign clearBusy = r_clr_busy && !reset;
  assign w_issue = (r_state == IDLE || r_state == CLEAR) && w_cand;
  // A new clearReq always restarts from word 0, even mid-sweep
  always_ff @(posedge mainClk) begin
    if (reset) begin
      r_clr_busy <= 1'b0;
      r_clr_cnt <= '0;
    end else if (clearReq) begin
      r_clr_busy <= 1'b1;
      r_clr_cnt <= '0;
    end else if (r_state == CLEAR && !w_cand) begin
      r_clr_cnt <= r_clr_cnt + 9'd1;
      r_clr_busy <= r_clr_cnt != 9'(NUM_WORDS-1);
    end
  end
`else
  assign w_clr_busy = 1'b0;
  assign w_issue = r_state == IDLE && w_cand;
`endif
  assign w_pop = r_state == IDLE && !w_cand && !w_clr_busy && !w_empty && !reset;
  fb_wr_fifo #(.DEPTH(FIFO_DEPTH), .W(14)) u_fifo (
    .clk(mainClk), .rst(reset), .push(wrValid && wrReady), .pop(w_pop),
    .din({wrAddr, wrData}), .dout(w_head), .full(w_full), .empty(w_empty)
  );
  always_ff @(posedge mainClk)
    r_state <= reset ? IDLE : w_next;
  always_comb begin
    w_next = IDLE;
    if (r_state == IDLE) w_next = w_cand ? RD_WAIT : w_pop ? RMW_WR : IDLE;
`ifdef FB_CLEAR_EN
    if (r_state == IDLE && !w_cand && r_clr_busy) w_next = CLEAR;
    if (r_state == CLEAR) w_next = w_cand ? RD_WAIT : (r_clr_cnt == 9'(NUM_WORDS-1)) ? IDLE : CLEAR;
`endif
  end
  always_comb begin
    ramAddr = '0;
    ramDataIn = '0;
    ramWren = 1'b0;
    if (!reset) begin
      if (w_issue) ramAddr = {5'd0, w_rd_addr};
      else if (w_pop) ramAddr = {5'd0, w_head[13:5]};
      else if (r_state == RMW_WR) begin
        ramAddr = {5'd0, r_hold_addr[11:3]};
        ramDataIn = merge_pix(ramDataOut, r_hold_addr[2:0], r_hold_data);
        ramWren = 1'b1;
      end
`ifdef FB_CLEAR_EN
      else if (r_state == CLEAR) begin
        ramAddr = {5'd0, r_clr_cnt};
        ramWren = 1'b1;
      end
`endif
    end
  end
  // A read arriving while busy is parked; a second one while parked is dropped
  always_ff @(posedge mainClk) begin
    if (reset) begin
      r_pend <= 1'b0;
      r_pend_addr <= '0;
      r_ovf <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data <= '0;
      r_hold_addr <= '0;
      r_hold_data <= '0;
    end else begin
      r_rd_valid <= r_state == RD_WAIT;
      if (r_state == RD_WAIT) r_rd_data <= ramDataOut;
      if (rdReq && r_pend) r_ovf <= 1'b1;
      r_pend <= !w_issue && (r_pend || rdReq);
      if (rdReq && !r_pend && !w_issue) r_pend_addr <= rdAddr;
      if (w_pop) {r_hold_addr, r_hold_data} <= w_head;
    end
  end
endmodule

// File: tb/tb_framebuffer_arbiter.sv
// tb_framebuffer_arbiter: directed self-checking bench with an SPRAM model and write log.
// Exercises the clear sweep only when FB_CLEAR_EN is defined.
module tb_framebuffer_arbiter;
  logic mainClk = 1'b0, reset = 1'b1, wrValid = 1'b0, rdReq = 1'b0;
  logic [11:0] wrAddr = '0;
  logic [1:0] wrData = '0;
  logic [8:0] rdAddr = '0;
  logic wrReady, rdValid, rdOverflow, ramWren;
  logic [15:0] rdData, ramDataIn, ramDataOut;
  logic [13:0] ramAddr;
  logic [3:0] ramMaskWren;
`ifdef FB_CLEAR_EN
  logic clearReq = 1'b0, clearBusy;
`endif
  logic [15:0] mem [512];
  logic pl_en = 1'b0;
  logic [8:0] pl_addr = '0;
  logic [15:0] pl_data = '0;
  logic [8:0] wa [$];
  logic [15:0] wd [$];
  int wcy [$];
  int cyc = 0, n_cmp = 0, n_bad = 0;

  framebuffer_arbiter dut (
    .mainClk(mainClk), .reset(reset), .wrValid(wrValid), .wrAddr(wrAddr), .wrData(wrData),
    .wrReady(wrReady), .rdReq(rdReq), .rdAddr(rdAddr), .rdValid(rdValid), .rdData(rdData),
    .rdOverflow(rdOverflow), .ramAddr(ramAddr), .ramDataIn(ramDataIn), .ramMaskWren(ramMaskWren),
    .ramWren(ramWren),
`ifdef FB_CLEAR_EN
    .clearReq(clearReq), .clearBusy(clearBusy),
`endif
    .ramDataOut(ramDataOut)
  );

  always #5 mainClk = ~mainClk;

  always @(posedge mainClk) begin
    cyc <= cyc + 1;
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ramWren) mem[ramAddr[8:0]] <= ramDataIn;
    ramDataOut <= mem[ramAddr[8:0]];
    if (ramWren) begin
      wa.push_back(ramAddr[8:0]);
      wd.push_back(ramDataIn);
      wcy.push_back(cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic step();
    @(negedge mainClk);
    #1;
  endtask

  task automatic preload(input logic [8:0] a, input logic [15:0] d);
    step();
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    preload(9'd1, 16'h0000);
    for (int k = 0; k < 8; k++) preload(9'(16 + k), 16'hFFFF);
    preload(9'd30, 16'h0000);
    preload(9'd40, 16'h0000);
    preload(9'd50, 16'h1234);
    preload(9'd5, 16'hAAAA);
    #1;
    n_cmp++; if (ramWren !== 1'b0) begin n_bad++; $display("FAIL rst_wren: got %b want 0", ramWren); end
    n_cmp++; if (ramMaskWren !== 4'b1111) begin n_bad++; $display("FAIL rst_mask: got %b want 1111", ramMaskWren); end
    n_cmp++; if (wrReady !== 1'b0) begin n_bad++; $display("FAIL rst_wrready: got %b want 0", wrReady); end
    n_cmp++; if (rdValid !== 1'b0 || rdData !== 16'h0) begin n_bad++; $display("FAIL rst_rd: got %b/%h want 0/0000", rdValid, rdData); end
    n_cmp++; if (rdOverflow !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b want 0", rdOverflow); end
    n_cmp++; if (ramAddr !== 14'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", ramAddr); end
    step();
    reset = 1'b0;
    #1;
    n_cmp++; if (wrReady !== 1'b1) begin n_bad++; $display("FAIL post_rst_wrready: got %b want 1", wrReady); end
  endtask

  task automatic test_single_write();
    int b;
    b = wa.size();
    step();
    wrValid = 1'b1; wrAddr = 12'h00B; wrData = 2'b11;
    step();
    wrValid = 1'b0;
    #1;
    n_cmp++; if (ramAddr !== 14'd1 || ramWren !== 1'b0) begin n_bad++; $display("FAIL sw_rd_issue: got addr %h wren %b want 1/0", ramAddr, ramWren); end
    step();
    n_cmp++; if (ramWren !== 1'b1 || ramAddr !== 14'd1 || ramDataIn !== 16'h00C0) begin n_bad++; $display("FAIL sw_write: got wren %b addr %h data %h want 1/1/00C0", ramWren, ramAddr, ramDataIn); end
    step();
    n_cmp++; if (ramWren !== 1'b0) begin n_bad++; $display("FAIL sw_after: got wren %b want 0", ramWren); end
    n_cmp++; if (wa.size() - b != 1) begin n_bad++; $display("FAIL sw_count: got %0d writes want 1", wa.size() - b); end
  endtask

  task automatic test_read_latency();
    step();
    rdReq = 1'b1; rdAddr = 9'd1;
    #1;
    n_cmp++; if (ramAddr !== 14'd1 || ramWren !== 1'b0) begin n_bad++; $display("FAIL rl_issue: got addr %h wren %b want 1/0", ramAddr, ramWren); end
    step();
    rdReq = 1'b0;
    n_cmp++; if (rdValid !== 1'b0) begin n_bad++; $display("FAIL rl_t1: got rdValid %b want 0", rdValid); end
    step();
    n_cmp++; if (rdValid !== 1'b1 || rdData !== 16'h00C0) begin n_bad++; $display("FAIL rl_t2: got %b/%h want 1/00C0", rdValid, rdData); end
    step();
    n_cmp++; if (rdValid !== 1'b0) begin n_bad++; $display("FAIL rl_t3: got rdValid %b want 0", rdValid); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_d [8] = '{16'hFFFC, 16'hFFF3, 16'hFFCF, 16'hFF3F, 16'hFCFF, 16'hF3FF, 16'hCFFF, 16'h3FFF};
    int b, pushed, low_at, bad;
    b = wa.size(); pushed = 0; low_at = -1; bad = 0;
    for (int c = 0; pushed < 8 && c < 40; c++) begin
      step();
      if (wrReady) begin
        wrValid = 1'b1; wrAddr = 12'h080 + 12'(pushed * 9); wrData = 2'b00; pushed++;
      end else begin
        wrValid = 1'b0;
        if (low_at < 0) low_at = c;
      end
    end
    step();
    wrValid = 1'b0;
    n_cmp++; if (low_at != 7) begin n_bad++; $display("FAIL b2b_full: wrReady first low at cycle %0d want 7", low_at); end
    repeat (20) step();
    n_cmp++; if (wa.size() - b != 8) begin n_bad++; $display("FAIL b2b_count: got %0d writes want 8", wa.size() - b); end
    else begin
      for (int k = 0; k < 8; k++) begin
        if (wa[b+k] !== 9'(16 + k) || wd[b+k] !== exp_d[k]) bad++;
        if (k > 0 && wcy[b+k] - wcy[b+k-1] != 2) bad++;
      end
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL b2b_order: %0d entries wrong in order/data/spacing want 0", bad); end
    end
  endtask

  task automatic test_same_word();
    int b;
    b = wa.size();
    step();
    wrValid = 1'b1; wrAddr = {9'd30, 3'd2}; wrData = 2'b01;
    step();
    wrData = 2'b10;
    step();
    wrValid = 1'b0;
    repeat (6) step();
    n_cmp++; if (wa.size() - b != 2 || wd[b] !== 16'h0010 || wd[b+1] !== 16'h0020) begin n_bad++; $display("FAIL same_word: got %0d writes last %h want 2 writes 0010,0020", wa.size() - b, wd[wd.size()-1]); end
    n_cmp++; if (mem[30] !== 16'h0020) begin n_bad++; $display("FAIL same_word_ram: got %h want 0020", mem[30]); end
  endtask

  task automatic test_read_during_rmw();
    int extra;
    extra = 0;
    n_cmp++; if (rdOverflow !== 1'b0) begin n_bad++; $display("FAIL ovf_pre: got %b want 0", rdOverflow); end
    step();
    wrValid = 1'b1; wrAddr = {9'd40, 3'd0}; wrData = 2'b10;
    step();
    wrValid = 1'b0;
    step();
    rdReq = 1'b1; rdAddr = 9'd40;
    #1;
    n_cmp++; if (ramWren !== 1'b1 || ramDataIn !== 16'h0002) begin n_bad++; $display("FAIL rmw_rd_write: got wren %b data %h want 1/0002", ramWren, ramDataIn); end
    step();
    rdReq = 1'b1; rdAddr = 9'd7;
    #1;
    n_cmp++; if (ramAddr !== 14'd40 || ramWren !== 1'b0 || rdValid !== 1'b0) begin n_bad++; $display("FAIL rmw_rd_t1: got addr %h wren %b valid %b want 28/0/0", ramAddr, ramWren, rdValid); end
    step();
    rdReq = 1'b0;
    n_cmp++; if (rdValid !== 1'b0 || rdOverflow !== 1'b1) begin n_bad++; $display("FAIL rmw_rd_t2: got valid %b ovf %b want 0/1", rdValid, rdOverflow); end
    step();
    n_cmp++; if (rdValid !== 1'b1 || rdData !== 16'h0002) begin n_bad++; $display("FAIL rmw_rd_t3: got %b/%h want 1/0002", rdValid, rdData); end
    for (int k = 0; k < 4; k++) begin
      step();
      if (rdValid) extra++;
    end
    n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL rmw_rd_single: got %0d extra rdValid want 0", extra); end
  endtask

  task automatic test_reset_mid_rmw();
    int b;
    b = wa.size();
    step();
    wrValid = 1'b1; wrAddr = {9'd50, 3'd0}; wrData = 2'b11;
    step();
    wrAddr = {9'd51, 3'd1};
    step();
    wrValid = 1'b0; reset = 1'b1;
    #1;
    n_cmp++; if (ramWren !== 1'b0) begin n_bad++; $display("FAIL rrmw_wren: got %b want 0", ramWren); end
    step();
    reset = 1'b0;
    #1;
    n_cmp++; if (wrReady !== 1'b1 || rdOverflow !== 1'b0) begin n_bad++; $display("FAIL rrmw_flags: got ready %b ovf %b want 1/0", wrReady, rdOverflow); end
    repeat (6) step();
    n_cmp++; if (wa.size() != b) begin n_bad++; $display("FAIL rrmw_flush: got %0d writes want 0", wa.size() - b); end
    n_cmp++; if (mem[50] !== 16'h1234) begin n_bad++; $display("FAIL rrmw_ram: got %h want 1234", mem[50]); end
  endtask

`ifdef FB_CLEAR_EN
  task automatic test_clear();
    int b, got, bad, n;
    b = wa.size(); got = 0; bad = 0; n = 0;
    step();
    clearReq = 1'b1;
    step();
    clearReq = 1'b0;
    n_cmp++; if (clearBusy !== 1'b1) begin n_bad++; $display("FAIL clr_busy: got %b want 1", clearBusy); end
    while (wa.size() - b < 100 && n < 300) begin step(); n++; end
    rdReq = 1'b1; rdAddr = 9'd5;
    for (int k = 1; k <= 3; k++) begin
      step();
      rdReq = 1'b0;
      if (rdValid && got == 0) begin got = 1; if (rdData !== 16'h0) bad = 1; end
    end
    n_cmp++; if (got != 1 || bad != 0) begin n_bad++; $display("FAIL clr_read: got valid %0d data %h want 1/0000", got, rdData); end
    n = 0;
    while (clearBusy && n < 1000) begin step(); n++; end
    n_cmp++; if (clearBusy !== 1'b0) begin n_bad++; $display("FAIL clr_done: got busy %b want 0", clearBusy); end
    bad = 0;
    n_cmp++; if (wa.size() - b != 512) begin n_bad++; $display("FAIL clr_count: got %0d writes want 512", wa.size() - b); end
    else begin
      for (int k = 0; k < 512; k++) if (wa[b+k] !== 9'(k) || wd[b+k] !== 16'h0) bad++;
      n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL clr_seq: %0d wrong entries want 0", bad); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_read_latency();
    test_back_to_back();
    test_same_word();
    test_read_during_rmw();
    test_reset_mid_rmw();
`ifdef FB_CLEAR_EN
    test_clear();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
